// File: rtl/instr_mem_fetch.sv
// Word-organised instruction store: a load phase for the loader path, then a registered,
// stallable fetch path with sticky halt and range checking. INSTMEM_PARITY_EN adds word parity.
module instr_mem_fetch #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 11,
  parameter int                BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inLoadEn,
  input  logic              inLoadWe,
  input  logic [ADDR_W-1:0] inLoadAddr,
  input  logic [DATA_W-1:0] inLoadData,
  input  logic              inStart,
  input  logic [31:0]       inPC,
  input  logic              inFetchReq,
  input  logic              inStall,
  output logic [DATA_W-1:0] outInstruction,
  output logic              outValid,
  output logic              outHalt,
  output logic              outAddrErr,
  output logic              outParityErr,
  output logic [ADDR_W:0]   outLoadCount,
  output logic [1:0]        outState
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  function automatic logic word_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
`ifdef INSTMEM_PARITY_EN
  logic              par_mem [DEPTH] = '{default: 1'b0};
`endif

  logic [ADDR_W-1:0] idx;
  logic              oor;
  logic              perr;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] fetch_data;

  assign outState = state;

  // Load-phase writes; storage sits outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && inLoadWe) begin
      mem[inLoadAddr] <= inLoadData;
`ifdef INSTMEM_PARITY_EN
      par_mem[inLoadAddr] <= word_parity(inLoadData);
`endif
    end
  end

  // Fetch address decode, range check and parity check of the addressed word.
  always_comb begin
    if (BYTE_ADDR != 0) begin
      idx = ADDR_W'(inPC >> 2);
      oor = ((inPC >> (ADDR_W + 2)) != 32'd0) || (inPC[1:0] != 2'd0);
    end else begin
      idx = ADDR_W'(inPC);
      oor = (inPC >> ADDR_W) != 32'd0;
    end
    rd_word = mem[idx];
`ifdef INSTMEM_PARITY_EN
    perr = !oor && (word_parity(rd_word) != par_mem[idx]);
`else
    perr = 1'b0;
`endif
    if (oor || perr) begin
      fetch_data = '0;
    end else begin
      fetch_data = rd_word;
    end
  end

  // Phase control and registered fetch outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_LOAD;
      outInstruction <= '0;
      outValid       <= 1'b0;
      outHalt        <= 1'b0;
      outAddrErr     <= 1'b0;
      outParityErr   <= 1'b0;
      outLoadCount   <= '0;
    end else if (state != ST_LOAD && inLoadEn) begin
      state        <= ST_LOAD;
      outValid     <= 1'b0;
      outHalt      <= 1'b0;
      outAddrErr   <= 1'b0;
      outParityErr <= 1'b0;
      outLoadCount <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          outValid <= 1'b0;
          if (inLoadWe && outLoadCount != COUNT_MAX) begin
            outLoadCount <= outLoadCount + (ADDR_W + 1)'(1);
          end
          if (inStart) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!inStall) begin
            if (inFetchReq) begin
              outInstruction <= fetch_data;
              outValid       <= 1'b1;
              outAddrErr     <= oor;
              outParityErr   <= perr;
              // Only a genuinely read word can halt; error-substituted NOPs never do.
              if (!oor && !perr && fetch_data == HALT_WORD) begin
                outHalt <= 1'b1;
                state   <= ST_HALT;
              end
            end else begin
              outValid     <= 1'b0;
              outAddrErr   <= 1'b0;
              outParityErr <= 1'b0;
            end
          end
        end
        ST_HALT: begin
          outValid     <= 1'b0;
          outAddrErr   <= 1'b0;
          outParityErr <= 1'b0;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed self-checking bench for instr_mem_fetch (default parameters, BYTE_ADDR=0).
module tb_instr_mem_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        inLoadEn;
  logic        inLoadWe;
  logic [10:0] inLoadAddr;
  logic [31:0] inLoadData;
  logic        inStart;
  logic [31:0] inPC;
  logic        inFetchReq;
  logic        inStall;
  logic [31:0] outInstruction;
  logic        outValid;
  logic        outHalt;
  logic        outAddrErr;
  logic        outParityErr;
  logic [11:0] outLoadCount;
  logic [1:0]  outState;

  int tests  = 0;
  int failed = 0;

  instr_mem_fetch dut (
    .clk(clk), .reset(reset),
    .inLoadEn(inLoadEn), .inLoadWe(inLoadWe), .inLoadAddr(inLoadAddr), .inLoadData(inLoadData),
    .inStart(inStart), .inPC(inPC), .inFetchReq(inFetchReq), .inStall(inStall),
    .outInstruction(outInstruction), .outValid(outValid), .outHalt(outHalt),
    .outAddrErr(outAddrErr), .outParityErr(outParityErr),
    .outLoadCount(outLoadCount), .outState(outState)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] ins, input logic v,
                           input logic aerr, input logic [1:0] st);
    check({tag, ".instr"}, 64'(outInstruction), 64'(ins));
    check({tag, ".valid"}, 64'(outValid), 64'(v));
    check({tag, ".aerr"},  64'(outAddrErr), 64'(aerr));
    check({tag, ".state"}, 64'(outState), 64'(st));
  endtask

  initial begin
    reset = 1'b0; inLoadEn = 1'b0; inLoadWe = 1'b0; inLoadAddr = 11'd0; inLoadData = 32'd0;
    inStart = 1'b0; inPC = 32'd0; inFetchReq = 1'b0; inStall = 1'b0;
    #2;
    check_out("reset", 32'h0, 1'b0, 1'b0, 2'b00);
    check("reset.halt", 64'(outHalt), 64'd0);
    check("reset.count", 64'(outLoadCount), 64'd0);
    check("reset.perr", 64'(outParityErr), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Load three words; the last write coincides with start
    inLoadWe = 1'b1; inLoadAddr = 11'd0; inLoadData = 32'h0021_4821;
    tick();
    check("load.count1", 64'(outLoadCount), 64'd1);
    inLoadAddr = 11'd1; inLoadData = 32'h0043_2021;
    inLoadEn = 1'b1;
    tick();
    check("load.loaden_ignored", 64'(outState), 64'd0);
    inLoadEn = 1'b0;
    inLoadAddr = 11'd2; inLoadData = 32'hFFFF_FFFF; inStart = 1'b1;
    tick();
    inLoadWe = 1'b0; inStart = 1'b0;
    check("load.count3", 64'(outLoadCount), 64'd3);
    check_out("load.run", 32'h0, 1'b0, 1'b0, 2'b01);

    // Back-to-back fetches
    inFetchReq = 1'b1; inPC = 32'd0;
    tick();
    check_out("fetch0", 32'h0021_4821, 1'b1, 1'b0, 2'b01);
    inPC = 32'd1;
    tick();
    check_out("fetch1", 32'h0043_2021, 1'b1, 1'b0, 2'b01);

    // Stall holds the output; load writes in RUN are ignored
    inPC = 32'd0; inStall = 1'b1;
    inLoadWe = 1'b1; inLoadAddr = 11'd0; inLoadData = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 32'h0043_2021, 1'b1, 1'b0, 2'b01);
    end
    inLoadWe = 1'b0;
    inStall = 1'b0; inPC = 32'd2;
    tick();
    check_out("halt_word", 32'hFFFF_FFFF, 1'b1, 1'b0, 2'b10);
    check("halt.set", 64'(outHalt), 64'd1);
    inPC = 32'd0;
    tick();
    check_out("halted", 32'hFFFF_FFFF, 1'b0, 1'b0, 2'b10);
    check("halt.sticky", 64'(outHalt), 64'd1);

    // Reload clears halt and count; then range checks
    inLoadEn = 1'b1;
    tick();
    inLoadEn = 1'b0; inFetchReq = 1'b0;
    check_out("reload", 32'hFFFF_FFFF, 1'b0, 1'b0, 2'b00);
    check("reload.halt", 64'(outHalt), 64'd0);
    check("reload.count", 64'(outLoadCount), 64'd0);
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    check("restart.state", 64'(outState), 64'd1);
    inFetchReq = 1'b1; inPC = 32'h0000_07FF;
    tick();
    check_out("edge_7ff", 32'h0, 1'b1, 1'b0, 2'b01);
    inPC = 32'h0000_0001;
    tick();
    check_out("fetch1b", 32'h0043_2021, 1'b1, 1'b0, 2'b01);
    inPC = 32'h0000_0800;
    tick();
    check_out("oor_800", 32'h0, 1'b1, 1'b1, 2'b01);
    inFetchReq = 1'b0;
    tick();
    check_out("idle", 32'h0, 1'b0, 1'b0, 2'b01);

    // Reset in the middle of a pending fetch
    inFetchReq = 1'b1; inPC = 32'd1;
    tick();
    check_out("pre_reset", 32'h0043_2021, 1'b1, 1'b0, 2'b01);
    inPC = 32'd0;
    #2 reset = 1'b0;
    #1;
    check_out("async_reset", 32'h0, 1'b0, 1'b0, 2'b00);
    tick();
    check_out("reset_held", 32'h0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b1; inFetchReq = 1'b0; inStart = 1'b1;
    tick();
    inStart = 1'b0; inFetchReq = 1'b1; inPC = 32'd0;
    tick();
    check_out("retained", 32'h0021_4821, 1'b1, 1'b0, 2'b01);
    check("retained.count", 64'(outLoadCount), 64'd0);
    check("retained.perr", 64'(outParityErr), 64'd0);

`ifdef INSTMEM_PARITY_EN
    dut.mem[1] = dut.mem[1] ^ 32'h0000_0010;
    inPC = 32'd1;
    tick();
    check_out("parity", 32'h0, 1'b1, 1'b0, 2'b01);
    check("parity.err", 64'(outParityErr), 64'd1);
    inFetchReq = 1'b0;
    tick();
    check("parity.clear", 64'(outParityErr), 64'd0);
`endif

    // Load counter saturates at the memory depth
    inFetchReq = 1'b0; inLoadEn = 1'b1;
    tick();
    inLoadEn = 1'b0;
    inLoadWe = 1'b1; inLoadAddr = 11'd3; inLoadData = 32'd0;
    repeat (2048) tick();
    check("count.full", 64'(outLoadCount), 64'd2048);
    tick();
    check("count.sat", 64'(outLoadCount), 64'd2048);
    inLoadWe = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
